// File: rtl/stc_pkg.sv
// Shared types and helpers for the structured-sparse GEMM engine.
package stc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      OUTPUT  = 2'd2
   } stc_state_e;

   localparam logic MODE_DENSE    = 1'b0;
   localparam logic MODE_SPARSE24 = 1'b1;

   // Ceiling log2 for elaboration-time widths (returns 0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/stc_dot_lane.sv
// One MAC lane: TILE_K signed products of an A row against a B row per step,
// summed into a single DW_ACC value. In 2:4 sparse mode the compressed A
// element j is paired with dense B column 4*(j/2) + idx(j).
module stc_dot_lane
   import stc_pkg::*;
#(
   parameter int K       = 16,
   parameter int TILE_K  = 8,
   parameter int DW_DATA = 8,
   parameter int DW_ACC  = 32,
   parameter int KS_W    = 2
)
(
   input  logic [K*DW_DATA-1:0]      a_row_i,
   input  logic [K-1:0]              idx_row_i,
   input  logic [K*DW_DATA-1:0]      b_row_i,
   input  logic                      mode_i,
   input  logic [KS_W-1:0]           kstep_i,
   output logic signed [DW_ACC-1:0]  sum_o
);

   localparam int PW = 2 * DW_DATA;
   localparam int CW = clog2(K);
   localparam int JW = clog2(K / 2);

   logic signed [DW_DATA-1:0] a_arr [K];
   logic signed [DW_DATA-1:0] b_arr [K];
   logic [1:0]                idx_arr [K/2];

   int                        j_c;
   int                        col_c;
   logic [CW-1:0]             a_sel;
   logic [CW-1:0]             b_sel;
   logic [JW-1:0]             j_sel;
   logic signed [PW-1:0]      a_ext;
   logic signed [PW-1:0]      b_ext;
   logic signed [PW-1:0]      prod;
   logic signed [DW_ACC-1:0]  sum_c;

   // Products are sign-extended to the accumulator width before summing.
   function automatic logic signed [DW_ACC-1:0] sext_prod(input logic signed [PW-1:0] p);
      return DW_ACC'(p);
   endfunction

   for (genvar k = 0; k < K; k++) begin : g_unpack
      assign a_arr[k] = a_row_i[k*DW_DATA +: DW_DATA];
      assign b_arr[k] = b_row_i[k*DW_DATA +: DW_DATA];
   end

   for (genvar j = 0; j < K/2; j++) begin : g_idx
      assign idx_arr[j] = idx_row_i[j*2 +: 2];
   end

   // Column mux plus multiply-add tree for the TILE_K products of this step.
   always_comb begin
      sum_c = '0;
      j_c   = 0;
      col_c = 0;
      a_sel = '0;
      b_sel = '0;
      j_sel = '0;
      a_ext = '0;
      b_ext = '0;
      prod  = '0;
      for (int t = 0; t < TILE_K; t++) begin
         j_c = int'(kstep_i) * TILE_K + t;
         if (mode_i == MODE_SPARSE24) begin
            j_sel = JW'(j_c);
            col_c = 4 * (j_c / 2) + int'(idx_arr[j_sel]);
         end else begin
            col_c = j_c;
         end
         a_sel = CW'(j_c);
         b_sel = CW'(col_c);
         a_ext = PW'(a_arr[a_sel]);
         b_ext = PW'(b_arr[b_sel]);
         prod  = a_ext * b_ext;
         sum_c = sum_c + sext_prod(prod);
      end
   end

   assign sum_o = sum_c;

endmodule

// File: rtl/stc_gemm_engine.sv
// C = A * B^T engine: N MAC lanes, one output row of C per pass over K,
// dense or 2:4 structured-sparse A, ready/valid on load and result sides.
module stc_gemm_engine
   import stc_pkg::*;
#(
   parameter int M       = 16,
   parameter int N       = 16,
   parameter int K       = 16,
   parameter int TILE_K  = 8,
   parameter int DW_DATA = 8,
   parameter int DW_ACC  = 32
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic                      mode,
   input  logic [M*K*DW_DATA-1:0]    in_a,
   input  logic [M*K-1:0]            in_idx,
   input  logic [N*K*DW_DATA-1:0]    in_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N*DW_ACC-1:0]       out,
   output logic [clog2(M)-1:0]       out_row,
   output logic                      done
);

   localparam int S_DN = K / TILE_K;
   localparam int S_SP = K / (2 * TILE_K);
   localparam int KS_W = clog2(S_DN) + 1;
   localparam int RW   = clog2(M);

   stc_state_e               state_q, state_d;

   logic [M*K*DW_DATA-1:0]   a_q;
   logic [M*K-1:0]           idx_q;
   logic [N*K*DW_DATA-1:0]   b_q;
   logic                     mode_q;

   logic [RW-1:0]            row_q, row_d;
   logic [KS_W-1:0]          kstep_q, kstep_d;
   logic signed [DW_ACC-1:0] acc_q [N];
   logic signed [DW_ACC-1:0] acc_d [N];
   logic [N*DW_ACC-1:0]      out_q, out_d;
   logic [RW-1:0]            out_row_q, out_row_d;
   logic                     done_q, done_d;

   logic [K*DW_DATA-1:0]     a_dn_rows [M];
   logic [K*DW_DATA-1:0]     a_sp_rows [M];
   logic [K-1:0]             idx_rows  [M];
   logic [K*DW_DATA-1:0]     a_row;
   logic [K-1:0]             idx_row;
   logic signed [DW_ACC-1:0] lane_sum [N];

   logic                     last_step;
   logic                     last_row;

   assign last_step = (mode_q == MODE_SPARSE24) ? (kstep_q == KS_W'(S_SP - 1))
                                                : (kstep_q == KS_W'(S_DN - 1));
   assign last_row  = (row_q == RW'(M - 1));

   // Sparse A rows are packed densely in the low half of in_a, so a sparse
   // row sits at a different offset than a dense row with the same index.
   for (genvar m = 0; m < M; m++) begin : g_rows
      assign a_dn_rows[m] = a_q[m*K*DW_DATA +: K*DW_DATA];
      assign a_sp_rows[m] = {{(K/2*DW_DATA){1'b0}}, a_q[m*(K/2)*DW_DATA +: (K/2)*DW_DATA]};
      assign idx_rows[m]  = idx_q[m*K +: K];
   end

   assign a_row   = (mode_q == MODE_SPARSE24) ? a_sp_rows[row_q] : a_dn_rows[row_q];
   assign idx_row = idx_rows[row_q];

   for (genvar n = 0; n < N; n++) begin : g_lane
      stc_dot_lane #(
         .K       (K),
         .TILE_K  (TILE_K),
         .DW_DATA (DW_DATA),
         .DW_ACC  (DW_ACC),
         .KS_W    (KS_W)
      ) u_lane (
         .a_row_i   (a_row),
         .idx_row_i (idx_row),
         .b_row_i   (b_q[n*K*DW_DATA +: K*DW_DATA]),
         .mode_i    (mode_q),
         .kstep_i   (kstep_q),
         .sum_o     (lane_sum[n])
      );
   end

   // Operand capture: only an accepted load in IDLE updates these, and reset
   // in the same cycle blocks the capture.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == IDLE) && load_valid) begin
         a_q    <= in_a;
         idx_q  <= in_idx;
         b_q    <= in_b;
         mode_q <= mode;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load_valid) state_d = COMPUTE;
         COMPUTE: if (last_step)  state_d = OUTPUT;
         OUTPUT:  if (out_ready)  state_d = last_row ? IDLE : COMPUTE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      load_ready = (state_q == IDLE);
      out_valid  = (state_q == OUTPUT);
   end

   // Counter, accumulator and result-register next state; everything holds
   // while a row waits in OUTPUT without out_ready.
   always_comb begin
      row_d     = row_q;
      kstep_d   = kstep_q;
      out_d     = out_q;
      out_row_d = out_row_q;
      done_d    = 1'b0;
      for (int n = 0; n < N; n++) acc_d[n] = acc_q[n];
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               row_d   = '0;
               kstep_d = '0;
               for (int n = 0; n < N; n++) acc_d[n] = '0;
            end
         end
         COMPUTE: begin
            for (int n = 0; n < N; n++) acc_d[n] = acc_q[n] + lane_sum[n];
            if (last_step) begin
               kstep_d   = '0;
               out_row_d = row_q;
               for (int n = 0; n < N; n++) out_d[n*DW_ACC +: DW_ACC] = acc_q[n] + lane_sum[n];
            end else begin
               kstep_d = kstep_q + KS_W'(1);
            end
         end
         OUTPUT: begin
            if (out_ready) begin
               if (last_row) begin
                  done_d = 1'b1;
               end else begin
                  row_d = row_q + RW'(1);
                  for (int n = 0; n < N; n++) acc_d[n] = '0;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset discards any job in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_q     <= '0;
         kstep_q   <= '0;
         out_q     <= '0;
         out_row_q <= '0;
         done_q    <= 1'b0;
         for (int n = 0; n < N; n++) acc_q[n] <= '0;
      end else begin
         row_q     <= row_d;
         kstep_q   <= kstep_d;
         out_q     <= out_d;
         out_row_q <= out_row_d;
         done_q    <= done_d;
         for (int n = 0; n < N; n++) acc_q[n] <= acc_d[n];
      end
   end

   assign out     = out_q;
   assign out_row = out_row_q;
   assign done    = done_q;

endmodule

// File: tb/tb_stc_gemm_engine.sv
// Directed bench for stc_gemm_engine at M=N=4, K=8, TILE_K=2.
module tb_stc_gemm_engine;

   localparam int M    = 4;
   localparam int N    = 4;
   localparam int K    = 8;
   localparam int TK   = 2;
   localparam int DW   = 8;
   localparam int DA   = 32;
   localparam int S_DN = 4;
   localparam int S_SP = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             load_valid;
   logic             load_ready;
   logic             mode;
   logic [255:0]     in_a;
   logic [31:0]      in_idx;
   logic [255:0]     in_b;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out;
   logic [1:0]       out_row;
   logic             done;

   int               n_chk  = 0;
   int               n_fail = 0;

   logic [255:0]     a_ones;
   logic [255:0]     a_neg;
   logic [255:0]     a_sparse;
   logic [255:0]     a_rowscale;
   logic [255:0]     b_twos;
   logic [255:0]     b_pos;
   logic [255:0]     b_ramp;
   int               ne;
   logic             saw;

   always #5 clk = ~clk;

   stc_gemm_engine #(
      .M       (M),
      .N       (N),
      .K       (K),
      .TILE_K  (TK),
      .DW_DATA (DW),
      .DW_ACC  (DA)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .mode       (mode),
      .in_a       (in_a),
      .in_idx     (in_idx),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out        (out),
      .out_row    (out_row),
      .done       (done)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] lanes(input logic [31:0] v);
      return {4{v}};
   endfunction

   // Called just after a posedge; returns the number of posedges until out_valid.
   task automatic wait_valid(output int cnt);
      cnt = 0;
      @(negedge clk);
      while (!out_valid && cnt < 40) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      check("valid_seen", out_valid, 1'b1);
   endtask

   task automatic do_load(input logic [255:0] a, input logic [31:0] idx,
                          input logic [255:0] b, input logic md);
      @(posedge clk); #1;
      in_a = a; in_idx = idx; in_b = b; mode = md; load_valid = 1'b1;
      @(posedge clk); #1;
      load_valid = 1'b0;
   endtask

   // Drains all rows with out_ready high; row r lanes = base*(r+1) if scale.
   task automatic run_rows(input logic [31:0] base, input bit scale, input int s, input int lat0);
      int          cnt;
      logic [31:0] v;
      for (int r = 0; r < M; r++) begin
         wait_valid(cnt);
         check("row_latency", cnt, (r == 0) ? lat0 : s);
         v = scale ? base * (r + 1) : base;
         check("out", out, lanes(v));
         check("out_row", out_row, r);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("done", done, 1'b1);
      check("ready_at_done", load_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      a_ones   = {32{8'h01}};
      a_neg    = {32{8'h80}};
      a_sparse = {{16{8'h55}}, {16{8'h03}}};
      b_twos   = {32{8'h02}};
      b_pos    = {32{8'h7F}};
      for (int n = 0; n < N; n++)
         for (int c = 0; c < K; c++)
            b_ramp[(n*K + c)*8 +: 8] = 8'(c);
      for (int m = 0; m < M; m++)
         for (int k = 0; k < K; k++)
            a_rowscale[(m*K + k)*8 +: 8] = 8'(m + 1);

      reset = 1'b1; load_valid = 1'b0; mode = 1'b0;
      in_a = '0; in_idx = '0; in_b = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_load_ready", load_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out", out, 128'h0);
      check("rst_out_row", out_row, 2'd0);
      check("rst_done", done, 1'b0);

      // Dense: 8 * 1 * 2 = 16 per lane.
      do_load(a_ones, 32'h0, b_twos, 1'b0);
      run_rows(32'd16, 1'b0, S_DN, S_DN);

      // Sparse 2:4: columns 0,1,4,5 -> 3*(0+1+4+5) = 30.
      do_load(a_sparse, {4{8'h44}}, b_ramp, 1'b1);
      run_rows(32'd30, 1'b0, S_SP, S_SP);

      // Signed extremes: 8 * (-128 * 127) = -130048.
      do_load(a_neg, 32'h0, b_pos, 1'b0);
      run_rows(32'hFFFE0400, 1'b0, S_DN, S_DN);

      // Load pulse during COMPUTE with other data is ignored.
      do_load(a_ones, 32'h0, b_twos, 1'b0);
      in_a = a_neg; in_b = b_pos; load_valid = 1'b1;
      @(posedge clk); #1;
      load_valid = 1'b0;
      run_rows(32'd16, 1'b0, S_DN, S_DN - 1);

      // Backpressure: row r lanes = 16*(r+1).
      out_ready = 1'b0;
      do_load(a_rowscale, 32'h0, b_twos, 1'b0);
      wait_valid(ne);
      check("bp_lat0", ne, S_DN);
      check("bp_out0", out, lanes(32'd16));
      check("bp_row0", out_row, 2'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      wait_valid(ne);
      check("bp_lat1", ne, S_DN);
      check("bp_out1", out, lanes(32'd32));
      check("bp_row1", out_row, 2'd1);
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_hold_valid", out_valid, 1'b1);
         check("bp_hold_row", out_row, 2'd1);
         check("bp_hold_out", out, lanes(32'd32));
         check("bp_hold_done", done, 1'b0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_advance", out_valid, 1'b0);
      wait_valid(ne);
      check("bp_lat2", ne, S_DN);
      check("bp_out2", out, lanes(32'd48));
      check("bp_row2", out_row, 2'd2);
      @(posedge clk); #1;
      wait_valid(ne);
      check("bp_out3", out, lanes(32'd64));
      check("bp_row3", out_row, 2'd3);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_done", done, 1'b1);

      // Reset during COMPUTE of row 2.
      do_load(a_ones, 32'h0, b_twos, 1'b0);
      for (int r = 0; r < 2; r++) begin
         wait_valid(ne);
         check("rst_job_out", out, lanes(32'd16));
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out", out, 128'h0);
      check("midrst_load_ready", load_ready, 1'b1);
      check("midrst_done", done, 1'b0);
      saw = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done || out_valid) saw = 1'b1;
      end
      check("midrst_quiet", saw, 1'b0);

      // Load and reset in the same cycle: load is dropped.
      @(posedge clk); #1;
      reset = 1'b1; load_valid = 1'b1; in_a = a_ones; in_b = b_twos; mode = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; load_valid = 1'b0;
      saw = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid || !load_ready) saw = 1'b1;
      end
      check("rst_wins_load", saw, 1'b0);

      // Fresh job after reset restarts at row 0.
      do_load(a_neg, 32'h0, b_pos, 1'b0);
      run_rows(32'hFFFE0400, 1'b0, S_DN, S_DN);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
